// File: rtl/corner_pack_pkg.sv
// Word format shared by the corner packer: field positions, word type, pack helpers.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package corner_pack_pkg;

    localparam int TRAILER_BIT = 31;
    localparam int X_LSB       = 0;
    localparam int Y_LSB       = 10;
    localparam int CNT_LSB     = 0;
    localparam int IDX_LSB     = 16;

    typedef logic [31:0] corner_word_t;

    // Corner word: flag bit clear, y in [19:10], x in [9:0], everything else zero.
    function automatic corner_word_t pack_corner(input logic [9:0] x, input logic [9:0] y);
        corner_word_t w;
        w = '0;
        w[X_LSB +: 10] = x;
        w[Y_LSB +: 10] = y;
        return w;
    endfunction

    // Trailer word: flag bit set, 15-bit upper field (index or drop count), 16-bit count.
    function automatic corner_word_t pack_trailer(input logic [14:0] hi, input logic [15:0] cnt);
        corner_word_t w;
        w = '0;
        w[TRAILER_BIT]    = 1'b1;
        w[IDX_LSB +: 15]  = hi;
        w[CNT_LSB +: 16]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/corner_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy output; head word visible while not empty.
// Latency: a word written at edge N is visible on rd_dat right after edge N.
// Backpressure: writes are ignored when full (unless a read frees a slot that same cycle); rd_dat holds the last read word when empty.
module corner_sync_fifo #(
    parameter int  DEPTH = 512,
    parameter int  W     = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat,
    output logic         empty,
    output logic [AW:0]  level
);

    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [W-1:0]  last_q, last_d;
    logic          full;
    logic          do_wr;
    logic          do_rd;

    // Next-state for pointers, occupancy and the last-read holding register.
    always_comb begin
        full     = (level_q == LVL_FULL);
        empty    = (level_q == '0);
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        last_d   = do_rd ? mem_q[rd_ptr_q] : last_q;
        level_d  = level_q;
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        rd_dat = empty ? last_q : mem_q[rd_ptr_q];
        level  = level_q;
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end

    // Pointer, occupancy and holding-register state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: rtl/corner_axis_packer.sv
// Packs NMS corners into 32-bit AXI-Stream words plus a tlast trailer per frame (macro CORNER_PACK_DROP_CNT_EN puts drop count in trailer).
// Latency: corner sampled at cycle N into an empty FIFO is presented with tvalid at N+1.
// Backpressure: one FIFO slot is reserved for the trailer; corners arriving with no room or while a trailer is pending are dropped and flag overflow.
module corner_axis_packer
    import corner_pack_pkg::*;
#(
    parameter int  FIFO_DEPTH = 512,
    parameter int  COORD_W    = 10,
    parameter int  CNT_W      = 16,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               iscorner,
    input  logic [COORD_W-1:0] x_coord,
    input  logic [COORD_W-1:0] y_coord,
    input  logic               frame_end,
    output logic [31:0]        m_axis_tdata,
    output logic [3:0]         m_axis_tkeep,
    output logic               m_axis_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               overflow,
    output logic [LW-1:0]      fifo_level
);

    // CNT_W is expected to be <= 16 so the count fits the trailer field.
    localparam logic [LW-1:0]    LVL_FULL       = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]    LVL_CORNER_MAX = LW'(FIFO_DEPTH - 2);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

    logic               trailer_pending_q, trailer_pending_d;
    corner_word_t       trailer_word_q, trailer_word_d;
    logic [14:0]        frame_idx_q, frame_idx_d;
    logic [CNT_W-1:0]   corner_cnt_q, corner_cnt_d;
    logic               overflow_q, overflow_d;
`ifdef CORNER_PACK_DROP_CNT_EN
    logic [14:0]        drop_cnt_q, drop_cnt_d;
    logic [14:0]        drop_final;
`endif

    logic               fe;
    logic               trl_wr;
    logic               corner_acc;
    logic               corner_drop;
    logic               fifo_wr;
    corner_word_t       fifo_wr_dat;
    logic [CNT_W-1:0]   cnt_final;
    logic [14:0]        hi_field;
    logic               fifo_empty;
    logic [LW-1:0]      level;

    // Accept/drop decisions, FIFO write mux and next-state for frame bookkeeping.
    always_comb begin
        fe          = ce && frame_end;
        // Trailer may use the reserved last slot; corners may not.
        trl_wr      = trailer_pending_q && (level < LVL_FULL);
        corner_acc  = ce && iscorner && !trailer_pending_q && (level <= LVL_CORNER_MAX);
        corner_drop = ce && iscorner && !corner_acc;
        fifo_wr     = trl_wr || corner_acc;
        fifo_wr_dat = trl_wr ? trailer_word_q : pack_corner(10'(x_coord), 10'(y_coord));

        cnt_final = (corner_acc && (corner_cnt_q != '1)) ? corner_cnt_q + CNT_ONE : corner_cnt_q;
`ifdef CORNER_PACK_DROP_CNT_EN
        drop_final = (corner_drop && (drop_cnt_q != '1)) ? drop_cnt_q + 15'd1 : drop_cnt_q;
        hi_field   = drop_final;
        drop_cnt_d = drop_final;
`else
        hi_field   = frame_idx_q;
`endif

        trailer_pending_d = trailer_pending_q;
        trailer_word_d    = trailer_word_q;
        frame_idx_d       = frame_idx_q;
        corner_cnt_d      = cnt_final;
        // A frame end while an unwritten trailer is pending loses the older frame's trailer.
        overflow_d        = overflow_q || corner_drop || (fe && trailer_pending_q && !trl_wr);

        if (trl_wr) begin
            trailer_pending_d = 1'b0;
        end
        if (fe) begin
            trailer_pending_d = 1'b1;
            trailer_word_d    = pack_trailer(hi_field, 16'(cnt_final));
            frame_idx_d       = frame_idx_q + 15'd1;
            corner_cnt_d      = '0;
`ifdef CORNER_PACK_DROP_CNT_EN
            drop_cnt_d        = '0;
`endif
        end
    end

    // Frame bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            trailer_pending_q <= 1'b0;
            trailer_word_q    <= '0;
            frame_idx_q       <= '0;
            corner_cnt_q      <= '0;
            overflow_q        <= 1'b0;
`ifdef CORNER_PACK_DROP_CNT_EN
            drop_cnt_q        <= '0;
`endif
        end else begin
            trailer_pending_q <= trailer_pending_d;
            trailer_word_q    <= trailer_word_d;
            frame_idx_q       <= frame_idx_d;
            corner_cnt_q      <= corner_cnt_d;
            overflow_q        <= overflow_d;
`ifdef CORNER_PACK_DROP_CNT_EN
            drop_cnt_q        <= drop_cnt_d;
`endif
        end
    end

    corner_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (fifo_wr),
        .wr_dat (fifo_wr_dat),
        .rd_en  (m_axis_tready),
        .rd_dat (m_axis_tdata),
        .empty  (fifo_empty),
        .level  (level)
    );

    // Stream outputs: tlast is simply the trailer flag bit of the head word.
    always_comb begin
        m_axis_tvalid = !fifo_empty;
        m_axis_tlast  = m_axis_tdata[TRAILER_BIT];
        m_axis_tkeep  = 4'hF;
        overflow      = overflow_q;
        fifo_level    = level;
    end

endmodule

// File: tb/tb_corner_axis_packer.sv
// Directed self-checking bench for corner_axis_packer with an 8-entry FIFO.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: one scenario toggles tready pseudo-randomly and checks output stability.
module tb_corner_axis_packer;

    localparam int DEPTH = 8;
`ifdef CORNER_PACK_DROP_CNT_EN
    localparam logic [31:0] EXP_OVF_TRL = 32'h80030007;
    localparam logic [31:0] EXP_F1_TRL  = 32'h80000000;
`else
    localparam logic [31:0] EXP_OVF_TRL = 32'h80000007;
    localparam logic [31:0] EXP_F1_TRL  = 32'h80010000;
`endif

    logic        clk = 1'b0;
    logic        rst, ce, iscorner, frame_end;
    logic [9:0]  x_coord, y_coord;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast, tvalid, tready, overflow;
    logic [3:0]  fifo_level;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] got_dat[$];
    logic        got_last[$];

    corner_axis_packer #(.FIFO_DEPTH(DEPTH), .COORD_W(10), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .iscorner      (iscorner),
        .x_coord       (x_coord),
        .y_coord       (y_coord),
        .frame_end     (frame_end),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tlast  (tlast),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .overflow      (overflow),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic pix(input logic c, input int x, input int y, input logic fe);
        ce        = 1'b1;
        iscorner  = c;
        x_coord   = x[9:0];
        y_coord   = y[9:0];
        frame_end = fe;
        tick;
        ce        = 1'b0;
        iscorner  = 1'b0;
        frame_end = 1'b0;
    endtask

    // Drains up to n words with tready held high, bounded by budget cycles.
    task automatic collect(input int n, input int budget);
        got_dat.delete();
        got_last.delete();
        tready = 1'b1;
        for (int c = 0; c < budget && got_dat.size() < n; c++) begin
            if (tvalid) begin
                got_dat.push_back(tdata);
                got_last.push_back(tlast);
            end
            tick;
        end
        tready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; ce = 1'b0; iscorner = 1'b0; frame_end = 1'b0;
        x_coord = '0; y_coord = '0; tready = 1'b0;
        tick;
        tick;
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
        total++; if (tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata: got %h want 00000000", tdata); end
        total++; if (tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %b want 0", tlast); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        total++; if (tkeep !== 4'hF) begin bad++; $display("FAIL reset_tkeep: got %h want f", tkeep); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [31:0] exp_w [4];
        exp_w = '{32'h00001C05, 32'h0000027F, 32'h00077C00, 32'h80000003};
        do_reset;
        pix(1'b1, 5, 7, 1'b0);
        total++; if (tvalid !== 1'b1 || tdata !== 32'h00001C05) begin
            bad++; $display("FAIL basic_latency: got vld=%b dat=%h want vld=1 dat=00001c05", tvalid, tdata);
        end
        pix(1'b1, 639, 0, 1'b0);
        pix(1'b1, 0, 479, 1'b0);
        pix(1'b0, 0, 0, 1'b1);
        tick;
        total++; if (fifo_level !== 4'd4) begin bad++; $display("FAIL basic_level: got %0d want 4", fifo_level); end
        collect(4, 50);
        total++; if (got_dat.size() != 4) begin bad++; $display("FAIL basic_count: got %0d want 4", got_dat.size()); end
        for (int i = 0; i < got_dat.size() && i < 4; i++) begin
            total++; if (got_dat[i] !== exp_w[i] || got_last[i] !== (i == 3)) begin
                bad++; $display("FAIL basic_word%0d: got %h last=%b want %h last=%b", i, got_dat[i], got_last[i], exp_w[i], i == 3);
            end
        end
        total++; if (tvalid !== 1'b0 || tdata !== 32'h80000003) begin
            bad++; $display("FAIL basic_empty_hold: got vld=%b dat=%h want vld=0 dat=80000003", tvalid, tdata);
        end
    endtask

    task automatic test_same_cycle;
        do_reset;
        pix(1'b1, 1, 1, 1'b1);
        tick;
        collect(2, 20);
        total++; if (got_dat.size() != 2) begin bad++; $display("FAIL same_count: got %0d want 2", got_dat.size()); end
        if (got_dat.size() == 2) begin
            total++; if (got_dat[0] !== 32'h00000401 || got_last[0] !== 1'b0) begin
                bad++; $display("FAIL same_corner: got %h last=%b want 00000401 last=0", got_dat[0], got_last[0]);
            end
            total++; if (got_dat[1] !== 32'h80000001 || got_last[1] !== 1'b1) begin
                bad++; $display("FAIL same_trailer: got %h last=%b want 80000001 last=1", got_dat[1], got_last[1]);
            end
        end
    endtask

    task automatic test_overflow;
        do_reset;
        tready = 1'b0;
        for (int i = 0; i < 10; i++) pix(1'b1, i, 0, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        total++; if (fifo_level !== 4'd7) begin bad++; $display("FAIL ovf_level7: got %0d want 7", fifo_level); end
        pix(1'b0, 0, 0, 1'b1);
        tick;
        total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL ovf_level8: got %0d want 8", fifo_level); end
        collect(8, 50);
        total++; if (got_dat.size() != 8) begin bad++; $display("FAIL ovf_count: got %0d want 8", got_dat.size()); end
        for (int i = 0; i < got_dat.size() && i < 7; i++) begin
            total++; if (got_dat[i] !== 32'(i) || got_last[i] !== 1'b0) begin
                bad++; $display("FAIL ovf_word%0d: got %h last=%b want %h last=0", i, got_dat[i], got_last[i], 32'(i));
            end
        end
        if (got_dat.size() == 8) begin
            total++; if (got_dat[7] !== EXP_OVF_TRL || got_last[7] !== 1'b1) begin
                bad++; $display("FAIL ovf_trailer: got %h last=%b want %h last=1", got_dat[7], got_last[7], EXP_OVF_TRL);
            end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_frame_index;
        do_reset;
        pix(1'b0, 0, 0, 1'b1);
        tick;
        iscorner = 1'b1; x_coord = 10'd3; y_coord = 10'd3; ce = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        iscorner = 1'b0;
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL idx_ce_gate: got level %0d want 1", fifo_level); end
        pix(1'b0, 0, 0, 1'b1);
        tick;
        collect(2, 20);
        total++; if (got_dat.size() != 2) begin bad++; $display("FAIL idx_count: got %0d want 2", got_dat.size()); end
        if (got_dat.size() == 2) begin
            total++; if (got_dat[0] !== 32'h80000000 || got_last[0] !== 1'b1) begin
                bad++; $display("FAIL idx_frame0: got %h last=%b want 80000000 last=1", got_dat[0], got_last[0]);
            end
            total++; if (got_dat[1] !== EXP_F1_TRL || got_last[1] !== 1'b1) begin
                bad++; $display("FAIL idx_frame1: got %h last=%b want %h last=1", got_dat[1], got_last[1], EXP_F1_TRL);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_w[$];
        int          k;
        logic        hold, hold_last, r;
        logic [31:0] hold_dat;
        for (int i = 0; i < 6; i++) exp_w.push_back(32'((2 * i + 1) * 1024 + 10 * i + 3));
        exp_w.push_back(32'h80000006);
        do_reset;
        k = 0;
        hold = 1'b0; hold_dat = '0; hold_last = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    pix(1'b1, 10 * i + 3, 2 * i + 1, 1'b0);
                    tick;
                end
                pix(1'b0, 0, 0, 1'b1);
            end
            begin
                for (int c = 0; c < 400 && k < 7; c++) begin
                    if (hold) begin
                        total++; if (tvalid !== 1'b1 || tdata !== hold_dat || tlast !== hold_last) begin
                            bad++; $display("FAIL bp_hold: got vld=%b dat=%h last=%b want vld=1 dat=%h last=%b",
                                            tvalid, tdata, tlast, hold_dat, hold_last);
                        end
                    end
                    r = 1'($urandom_range(0, 1));
                    tready = r;
                    if (tvalid && r) begin
                        total++; if (tdata !== exp_w[k] || tlast !== (k == 6)) begin
                            bad++; $display("FAIL bp_order%0d: got %h last=%b want %h last=%b", k, tdata, tlast, exp_w[k], k == 6);
                        end
                        k++;
                    end
                    hold      = tvalid && !r;
                    hold_dat  = tdata;
                    hold_last = tlast;
                    tick;
                end
            end
        join
        tready = 1'b0;
        total++; if (k != 7) begin bad++; $display("FAIL bp_count: got %0d want 7", k); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        tready = 1'b0;
        for (int i = 1; i <= 3; i++) pix(1'b1, i, 2, 1'b0);
        pix(1'b0, 0, 0, 1'b1);
        pix(1'b1, 9, 9, 1'b0);
        pix(1'b0, 0, 0, 1'b1);
        total++; if (overflow !== 1'b1 || fifo_level !== 4'd4) begin
            bad++; $display("FAIL rmid_pre: got ovf=%b level=%0d want ovf=1 level=4", overflow, fifo_level);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++; if (tvalid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL rmid_post: got vld=%b level=%0d ovf=%b want 0 0 0", tvalid, fifo_level, overflow);
        end
        tick;
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL rmid_no_trailer: got level %0d want 0", fifo_level); end
        pix(1'b0, 0, 0, 1'b1);
        tick;
        collect(1, 20);
        total++; if (got_dat.size() != 1) begin bad++; $display("FAIL rmid_count: got %0d want 1", got_dat.size()); end
        if (got_dat.size() == 1) begin
            total++; if (got_dat[0] !== 32'h80000000 || got_last[0] !== 1'b1) begin
                bad++; $display("FAIL rmid_trailer: got %h last=%b want 80000000 last=1", got_dat[0], got_last[0]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_same_cycle;
        test_overflow;
        test_frame_index;
        test_backpressure;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
